// File: rtl/noise_regif.sv
// Register front end for the APU noise channel: decodes CPU writes, holds the
// channel registers, issues write strobes and owns the noise length counter.
module noise_regif #(
    parameter logic [15:0] BASE_ADDR = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dout_vld,
    input  logic        half_frame,
    output logic [7:0]  r400c,
    output logic [7:0]  r400e,
    output logic [7:0]  r400f,
    output logic        wr400c,
    output logic        wr400e,
    output logic        wr400f,
    output logic        env_start,
    output logic [7:0]  length_cnt,
    output logic        length_active,
    output logic        noise_en
);

    localparam logic [15:0] ADDR_400C = BASE_ADDR + 16'h000C;
    localparam logic [15:0] ADDR_400E = BASE_ADDR + 16'h000E;
    localparam logic [15:0] ADDR_400F = BASE_ADDR + 16'h000F;
    localparam logic [15:0] ADDR_4015 = BASE_ADDR + 16'h0015;

    logic       hit_400c_s;
    logic       hit_400e_s;
    logic       hit_400f_s;
    logic       hit_4015_wr_s;
    logic       hit_4015_rd_s;
    logic [7:0] length_next_s;

    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;
            5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;
            5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;
            5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;
            5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;
            5'd9:  val = 8'd8;
            5'd10: val = 8'd60;
            5'd11: val = 8'd10;
            5'd12: val = 8'd14;
            5'd13: val = 8'd12;
            5'd14: val = 8'd26;
            5'd15: val = 8'd14;
            5'd16: val = 8'd12;
            5'd17: val = 8'd16;
            5'd18: val = 8'd24;
            5'd19: val = 8'd18;
            5'd20: val = 8'd48;
            5'd21: val = 8'd20;
            5'd22: val = 8'd96;
            5'd23: val = 8'd22;
            5'd24: val = 8'd192;
            5'd25: val = 8'd24;
            5'd26: val = 8'd72;
            5'd27: val = 8'd26;
            5'd28: val = 8'd16;
            5'd29: val = 8'd28;
            5'd30: val = 8'd32;
            5'd31: val = 8'd30;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    // A write that coincides with a read wins; the read is dropped.
    assign hit_400c_s    = cpu_wr && (cpu_addr == ADDR_400C);
    assign hit_400e_s    = cpu_wr && (cpu_addr == ADDR_400E);
    assign hit_400f_s    = cpu_wr && (cpu_addr == ADDR_400F);
    assign hit_4015_wr_s = cpu_wr && (cpu_addr == ADDR_4015);
    assign hit_4015_rd_s = cpu_rd && !cpu_wr && (cpu_addr == ADDR_4015);
    assign length_active = (length_cnt != 8'd0);

    // Next length count: disable, then table load, then half-frame decrement.
    always_comb begin
        length_next_s = length_cnt;
        if (hit_4015_wr_s && !cpu_din[3]) begin
            length_next_s = 8'd0;
        end else if (hit_400f_s && noise_en) begin
            length_next_s = length_lookup(cpu_din[7:3]);
        end else if (half_frame && !r400c[5] && (length_cnt != 8'd0)) begin
            length_next_s = length_cnt - 8'd1;
        end else begin
            length_next_s = length_cnt;
        end
    end

    // Channel registers, strobes and length state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r400c      <= 8'd0;
            r400e      <= 8'd0;
            r400f      <= 8'd0;
            wr400c     <= 1'b0;
            wr400e     <= 1'b0;
            wr400f     <= 1'b0;
            env_start  <= 1'b0;
            length_cnt <= 8'd0;
            noise_en   <= 1'b0;
        end else begin
            wr400c     <= hit_400c_s;
            wr400e     <= hit_400e_s;
            wr400f     <= hit_400f_s;
            env_start  <= hit_400f_s;
            length_cnt <= length_next_s;
            if (hit_400c_s) begin
                r400c <= cpu_din;
            end
            if (hit_400e_s) begin
                r400e <= cpu_din;
            end
            if (hit_400f_s) begin
                r400f <= cpu_din;
            end
            if (hit_4015_wr_s) begin
                noise_en <= cpu_din[3];
            end
        end
    end

    // Status read port; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_dout     <= 8'd0;
            cpu_dout_vld <= 1'b0;
        end else begin
            cpu_dout_vld <= hit_4015_rd_s;
            if (hit_4015_rd_s) begin
                cpu_dout <= {4'b0000, length_active, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_noise_regif.sv
// Scoreboard bench for noise_regif: a reference model pushes expected outputs
// when each bus cycle is driven; they are popped and compared after the edge.
module tb_noise_regif;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_vld;
    logic        half_frame = 1'b0;
    logic [7:0]  r400c, r400e, r400f;
    logic        wr400c, wr400e, wr400f, env_start;
    logic [7:0]  length_cnt;
    logic        length_active;
    logic        noise_en;

    typedef struct {
        logic [7:0] c;
        logic [7:0] e;
        logic [7:0] f;
        logic [3:0] stb;
        logic [7:0] cnt;
        logic       act;
        logic       en;
        logic [7:0] dout;
        logic       vld;
    } exp_t;

    exp_t sb_q[$];

    int tests_run = 0;
    int fail_cnt  = 0;

    int lt_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    logic [7:0] m_c = 8'h00, m_e = 8'h00, m_f = 8'h00, m_cnt = 8'h00, m_dout = 8'h00;
    logic       m_en = 1'b0, m_vld = 1'b0;
    logic [3:0] m_stb = 4'h0;

    noise_regif dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_dout_vld  (cpu_dout_vld),
        .half_frame    (half_frame),
        .r400c         (r400c),
        .r400e         (r400e),
        .r400f         (r400f),
        .wr400c        (wr400c),
        .wr400e        (wr400e),
        .wr400f        (wr400f),
        .env_start     (env_start),
        .length_cnt    (length_cnt),
        .length_active (length_active),
        .noise_en      (noise_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Drive one bus cycle, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic w, input logic rd_i,
                        input logic [15:0] a, input logic [7:0] d, input logic hf);
        logic       hc, he, hff, h15w, h15r;
        logic [7:0] nc;
        exp_t       ex;
        exp_t       got;
        rst = r; cpu_wr = w; cpu_rd = rd_i; cpu_addr = a; cpu_din = d; half_frame = hf;
        hc   = w && (a == 16'h400C);
        he   = w && (a == 16'h400E);
        hff  = w && (a == 16'h400F);
        h15w = w && (a == 16'h4015);
        h15r = rd_i && !w && (a == 16'h4015);
        if (r) begin
            m_c = 8'h00; m_e = 8'h00; m_f = 8'h00; m_cnt = 8'h00;
            m_en = 1'b0; m_dout = 8'h00; m_vld = 1'b0; m_stb = 4'h0;
        end else begin
            nc = m_cnt;
            if (h15w && !d[3])
                nc = 8'h00;
            else if (hff && m_en)
                nc = lt_tab[d[7:3]][7:0];
            else if (hf && !m_c[5] && m_cnt != 8'h00)
                nc = m_cnt - 8'h01;
            m_vld = h15r;
            if (h15r) m_dout = {4'b0000, (m_cnt != 8'h00), 3'b000};
            if (hc) m_c = d;
            if (he) m_e = d;
            if (hff) m_f = d;
            if (h15w) m_en = d[3];
            m_cnt = nc;
            m_stb = {hc, he, hff, hff};
        end
        ex.c = m_c; ex.e = m_e; ex.f = m_f; ex.stb = m_stb; ex.cnt = m_cnt;
        ex.act = (m_cnt != 8'h00); ex.en = m_en; ex.dout = m_dout; ex.vld = m_vld;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("r400c", r400c, got.c);
            check("r400e", r400e, got.e);
            check("r400f", r400f, got.f);
            check("strobes", {wr400c, wr400e, wr400f, env_start}, got.stb);
            check("length_cnt", length_cnt, got.cnt);
            check("length_active", length_active, got.act);
            check("noise_en", noise_en, got.en);
            check("cpu_dout", cpu_dout, got.dout);
            check("cpu_dout_vld", cpu_dout_vld, got.vld);
        end
    endtask

    task automatic idle(input logic hf);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, hf);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic hf);
        step(1'b0, 1'b1, 1'b0, a, d, hf);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0);
    endtask

    logic [15:0] addr_set [6] = '{16'h400C, 16'h400D, 16'h400E, 16'h400F, 16'h4015, 16'h4000};

    initial begin
        // Reset and idle, then status read with empty counter.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        idle(1'b0);
        idle(1'b1);
        rd(16'h4015);
        idle(1'b0);

        // Enable and load index 1.
        wr(16'h4015, 8'h08, 1'b0);
        wr(16'h400F, 8'h08, 1'b0);
        idle(1'b0);
        rd(16'h4015);
        idle(1'b0);

        // Load index 3 and count down to zero with saturation.
        wr(16'h400C, 8'h00, 1'b0);
        wr(16'h400F, 8'h18, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        rd(16'h4015);

        // Halt holds the count; release and decrement once.
        wr(16'h400C, 8'h20, 1'b0);
        wr(16'h400F, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        wr(16'h400C, 8'h00, 1'b0);
        idle(1'b1);

        // Same-cycle priority: load beats tick, disable beats tick.
        wr(16'h400F, 8'h00, 1'b1);
        wr(16'h4015, 8'h00, 1'b1);

        // Disabled load, ignored address, back-to-back strobes, wr+rd collision.
        wr(16'h400F, 8'hF8, 1'b0);
        wr(16'h400D, 8'h55, 1'b0);
        wr(16'h400E, 8'h8A, 1'b0);
        wr(16'h400C, 8'h1F, 1'b0);
        wr(16'h400C, 8'h2E, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h4015, 8'h08, 1'b0);
        wr(16'h400F, 8'h08, 1'b1);
        idle(1'b1);

        // Reset mid-write while counting.
        step(1'b1, 1'b1, 1'b0, 16'h400F, 8'h40, 1'b1);
        idle(1'b0);

        // Randomised traffic over the decoded window.
        wr(16'h4015, 8'h08, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, addr_set[$urandom_range(0, 5)],
                 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/noise_regif.md
Name: noise_regif

Overview:
- CPU-facing register front end for the noise channel. It decodes CPU bus writes to $400C/$400E/$400F/$4015 and holds the channel register values.
- It issues single-cycle write strobes so the channel never has to edge-trigger on register data.
- It owns the noise length counter: table load, halt, enable, half-frame decrement. It also serves the $4015 status read.
- It sits between the CPU bus decode and the noise generator, in the clk domain.

Parameters:
- BASE_ADDR, 16'h4000, base of the APU register window. Channel offsets are $0C/$0E/$0F; status is at $15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_wr  in  1  write qualifier, one cycle per write.
- cpu_rd  in  1  read qualifier, one cycle per read.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data, registered.
- cpu_dout_vld  out  1  high the cycle after a decoded $4015 read.
- half_frame  in  1  one-cycle half-frame tick from the frame sequencer.
- r400c  out  8  held $400C value: bit5 halt/loop, bit4 const volume, bits3:0 volume/period.
- r400e  out  8  held $400E value: bit7 mode, bits3:0 period index.
- r400f  out  8  held $400F value: bits7:3 length index.
- wr400c, wr400e, wr400f  out  1 each  one-cycle strobe, asserted the cycle after the write.
- env_start  out  1  one-cycle pulse, asserted coincident with wr400f.
- length_cnt  out  8  current length counter.
- length_active  out  1  high when length_cnt != 0; gates the channel output.
- noise_en  out  1  $4015 bit3 latch.

Behaviour:
- Reset: all registers, strobes, length_cnt, noise_en, cpu_dout and cpu_dout_vld are 0. Reset has priority over every other event, including mid-write.
- Decode: a write hits only if cpu_wr=1 and cpu_addr equals BASE_ADDR plus the offset exactly. $400D and all other addresses are ignored and produce no strobe.
- Register writes:
  - The register updates on the clock edge that samples cpu_wr.
  - The matching strobe is high for exactly the next cycle, so the new value is already stable when the strobe is seen.
  - Back-to-back writes to the same register give consecutive strobe cycles, one per write.
- $4015 write: noise_en <= cpu_din[3]. If cpu_din[3]=0, length_cnt <= 0 on the same edge.
- Length load: on a $400F write with noise_en=1 (the value before this edge), length_cnt <= LT[cpu_din[7:3]]. If noise_en=0, no load, but the register is still stored and the strobes still fire.
- LT, 32 entries in decimal, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Decrement: on half_frame=1, if r400c[5]=0 and length_cnt!=0, length_cnt <= length_cnt-1.
  - Saturates at 0; never wraps.
  - Halt uses r400c as held before the edge.
- Same-cycle priority, highest first:
  1. rst.
  2. $4015 disable clears length_cnt; this beats a same-cycle tick.
  3. $400F load; this beats a same-cycle half_frame, which is dropped.
  4. Decrement.
- A $4015 enable and a $400F write cannot coincide, since there is one bus cycle per access.
- Status read: a cpu_rd hit on $4015 gives cpu_dout = {4'b0, length_active, 3'b0} and cpu_dout_vld=1 on the next cycle.
  - length_active is sampled at the read edge.
  - With no hit, cpu_dout holds its last value and cpu_dout_vld=0.
- cpu_wr and cpu_rd both high in the same cycle: the write is performed and the read is ignored.
- length_active is combinational from length_cnt.

Test Plan:
- Reset then idle → all outputs 0. Read $4015 → cpu_dout=8'h00, vld one cycle later.
- Write $4015=08, then $400F=8'h08 (index 1) → r400f=08; wr400f and env_start high one cycle; length_cnt=254; $4015 read bit3=1.
- With noise_en=1 and r400c=0, load index 3 (cnt 2) → two half_frame pulses give 1 then 0; a third pulse keeps 0; length_active falls after the second pulse.
- r400c=8'h20 (halt), length_cnt=10, five half_frame pulses → length_cnt stays 10. Clear halt, one pulse → 9.
- $400F write (index 0) coincident with half_frame → length_cnt=10, not 9. A $4015=00 write coincident with half_frame → length_cnt=0.
- noise_en=0, then write $400F=8'hF8 → r400f=F8, strobe fires, length_cnt stays 0. Write to $400D → no strobe, no register change. Assert rst mid-count → everything 0 next cycle.
